// File: rtl/teleport_sequencer.sv
// Level-flow controller: loads per-level teleport/spawn coordinates and runs the
// fade-out / level-advance / fade-in sequence around active play.
module teleport_sequencer #(
    parameter int               NUM_LEVELS  = 4,
    parameter int               FADE_DIV    = 4,
    parameter logic [10*NUM_LEVELS-1:0] TELE_X_TAB  = {10'd560, 10'd560, 10'd300, 10'd40},
    parameter logic [10*NUM_LEVELS-1:0] TELE_Y_TAB  = {10'd40,  10'd400, 10'd40,  10'd400},
    parameter logic [10*NUM_LEVELS-1:0] SPAWN_X_TAB = {10'd40,  10'd40,  10'd300, 10'd560},
    parameter logic [10*NUM_LEVELS-1:0] SPAWN_Y_TAB = {10'd400, 10'd40,  10'd400, 10'd40}
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       start,
    input  logic       restart,
    input  logic       reach_final,
    output logic [9:0] Teleport_X,
    output logic [9:0] Teleport_Y,
    output logic [9:0] Spawn_X,
    output logic [9:0] Spawn_Y,
    output logic       spawn_load,
    output logic       teleport_clear,
    output logic       freeze,
    output logic [3:0] fade,
    output logic [1:0] level,
    output logic       game_won
);

    localparam int         DIV_W     = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(FADE_DIV - 1);
    localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FADE_IN,
        S_PLAY,
        S_FADE_OUT,
        S_WIN
    } state_t;

    logic [9:0] tele_x_arr  [NUM_LEVELS];
    logic [9:0] tele_y_arr  [NUM_LEVELS];
    logic [9:0] spawn_x_arr [NUM_LEVELS];
    logic [9:0] spawn_y_arr [NUM_LEVELS];

    for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_tab
        assign tele_x_arr[gi]  = TELE_X_TAB[10*gi +: 10];
        assign tele_y_arr[gi]  = TELE_Y_TAB[10*gi +: 10];
        assign spawn_x_arr[gi] = SPAWN_X_TAB[10*gi +: 10];
        assign spawn_y_arr[gi] = SPAWN_Y_TAB[10*gi +: 10];
    end

    state_t           state_q, state_d;
    logic [1:0]       level_q, level_d;
    logic [3:0]       fade_q, fade_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             retry_q, retry_d;
    logic [9:0]       tele_x_q, tele_x_d;
    logic [9:0]       tele_y_q, tele_y_d;
    logic [9:0]       spawn_x_q, spawn_x_d;
    logic [9:0]       spawn_y_q, spawn_y_d;
    logic             spawn_load_q, spawn_load_d;
    logic             clear_q, clear_d;
    logic             freeze_q, freeze_d;
    logic             game_won_q, game_won_d;

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        fade_d       = fade_q;
        div_cnt_d    = div_cnt_q;
        retry_d      = retry_q;
        tele_x_d     = tele_x_q;
        tele_y_d     = tele_y_q;
        spawn_x_d    = spawn_x_q;
        spawn_y_d    = spawn_y_q;
        spawn_load_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_FADE_IN;
            end
            S_FADE_IN: begin
                if (fade_q == 4'd0) begin
                    state_d = S_PLAY;
                end else if (div_cnt_q == DIV_MAX) begin
                    div_cnt_d = '0;
                    fade_d    = fade_q - 4'd1;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_PLAY: begin
                if (reach_final || restart) begin
                    state_d   = S_FADE_OUT;
                    retry_d   = !reach_final;
                    fade_d    = 4'd0;
                    div_cnt_d = '0;
                end
            end
            S_FADE_OUT: begin
                if (fade_q == 4'd15) begin
                    if (retry_q) begin
                        state_d = S_LOAD;
                    end else if (level_q == LAST_LEVEL) begin
                        state_d = S_WIN;
                    end else begin
                        level_d = level_q + 2'd1;
                        state_d = S_LOAD;
                    end
                end else if (div_cnt_q == DIV_MAX) begin
                    div_cnt_d = '0;
                    fade_d    = fade_q + 4'd1;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_WIN: begin
                fade_d = 4'd15;
                if (start) begin
                    level_d = 2'd0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so the LOAD-cycle values are set on entry using the next level.
        if (state_d == S_LOAD) begin
            tele_x_d     = tele_x_arr[level_d];
            tele_y_d     = tele_y_arr[level_d];
            spawn_x_d    = spawn_x_arr[level_d];
            spawn_y_d    = spawn_y_arr[level_d];
            spawn_load_d = 1'b1;
            fade_d       = 4'd15;
            div_cnt_d    = '0;
            retry_d      = 1'b0;
        end

        clear_d    = (state_d != S_PLAY);
        freeze_d   = (state_d != S_PLAY);
        game_won_d = (state_d == S_WIN);
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            level_q      <= 2'd0;
            fade_q       <= 4'd15;
            div_cnt_q    <= '0;
            retry_q      <= 1'b0;
            tele_x_q     <= TELE_X_TAB[9:0];
            tele_y_q     <= TELE_Y_TAB[9:0];
            spawn_x_q    <= SPAWN_X_TAB[9:0];
            spawn_y_q    <= SPAWN_Y_TAB[9:0];
            spawn_load_q <= 1'b0;
            clear_q      <= 1'b1;
            freeze_q     <= 1'b1;
            game_won_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            fade_q       <= fade_d;
            div_cnt_q    <= div_cnt_d;
            retry_q      <= retry_d;
            tele_x_q     <= tele_x_d;
            tele_y_q     <= tele_y_d;
            spawn_x_q    <= spawn_x_d;
            spawn_y_q    <= spawn_y_d;
            spawn_load_q <= spawn_load_d;
            clear_q      <= clear_d;
            freeze_q     <= freeze_d;
            game_won_q   <= game_won_d;
        end
    end

    assign Teleport_X     = tele_x_q;
    assign Teleport_Y     = tele_y_q;
    assign Spawn_X        = spawn_x_q;
    assign Spawn_Y        = spawn_y_q;
    assign spawn_load     = spawn_load_q;
    assign teleport_clear = clear_q;
    assign freeze         = freeze_q;
    assign fade           = fade_q;
    assign level          = level_q;
    assign game_won       = game_won_q;

endmodule

// File: doc/teleport_sequencer.md
Name: teleport_sequencer

Overview:
Level-flow controller for the teleport datapath. It loads the teleport and kid spawn coordinates for the current level and holds the teleport's reach_final flag cleared outside active play. When reach_final rises, it runs a fade-out / level-advance / fade-in sequence. It sits between the menu logic, the kid motion block, the teleport block and the colour mapper, and runs on the frame clock.

Parameters:
NUM_LEVELS, 4, number of levels; legal range 1..4.
FADE_DIV, 4, frames per fade step; must be 1 or more.
TELE_X_TAB, {10'd560,10'd560,10'd300,10'd40}, teleport X per level, 10 bits each, level 0 in bits [9:0].
TELE_Y_TAB, {10'd40,10'd400,10'd40,10'd400}, teleport Y per level, same packing.
SPAWN_X_TAB, {10'd40,10'd40,10'd300,10'd560}, kid spawn X per level.
SPAWN_Y_TAB, {10'd400,10'd40,10'd400,10'd40}, kid spawn Y per level.

Ports:
frame_clk  in  1  frame clock; the only clock.
Reset_n  in  1  asynchronous, active-low reset.
start  in  1  game start / replay request; sampled in IDLE and WIN only.
restart  in  1  kid-death request; sampled in PLAY only.
reach_final  in  1  kid is inside the teleport; level signal from the teleport block.
Teleport_X  out  10  teleport Position_X.
Teleport_Y  out  10  teleport Position_Y.
Spawn_X  out  10  kid spawn X.
Spawn_Y  out  10  kid spawn Y.
spawn_load  out  1  one-cycle pulse; the kid block loads Spawn_X and Spawn_Y.
teleport_clear  out  1  drives the teleport block's Reset_h.
freeze  out  1  kid motion disable.
fade  out  4  screen darkening; 0 = normal, 15 = black.
level  out  2  current level index.
game_won  out  1  high in WIN.

Behaviour:
- States: IDLE, LOAD, FADE_IN, PLAY, FADE_OUT, WIN. All outputs are registered.
- Reset (Reset_n low, asynchronous) forces these values:
  - state = IDLE, level = 0, fade = 15, div_cnt = 0, retry = 0.
  - Teleport_X, Teleport_Y, Spawn_X, Spawn_Y = table entry 0.
  - spawn_load = 0, teleport_clear = 1, freeze = 1, game_won = 0.
- Reset asserted mid-sequence aborts immediately to the reset values. There is no resume.
- teleport_clear = 1 and freeze = 1 in every state except PLAY. In PLAY both are 0.
- IDLE: if start = 1, go to LOAD.
- LOAD (exactly 1 cycle):
  - Register table[level] into Teleport_X/Y and Spawn_X/Y.
  - spawn_load = 1 in this cycle only.
  - Set fade = 15, div_cnt = 0, retry = 0. Go to FADE_IN.
- FADE_IN:
  - div_cnt increments every cycle.
  - When div_cnt = FADE_DIV-1: div_cnt goes to 0 and fade decrements.
  - When fade = 0 at the start of a cycle, go to PLAY next cycle.
  - Duration: 15*FADE_DIV + 1 cycles.
- PLAY:
  - reach_final = 1: go to FADE_OUT with retry = 0.
  - Else restart = 1: go to FADE_OUT with retry = 1.
  - If both are high in the same cycle, reach_final wins.
  - On entry to FADE_OUT, fade = 0 and div_cnt = 0.
- FADE_OUT:
  - fade increments, mirroring FADE_IN.
  - When fade = 15 at the start of a cycle, the next step is one of:
    - retry = 1: go to LOAD, level unchanged.
    - retry = 0 and level = NUM_LEVELS-1: go to WIN.
    - Otherwise: level increments, then go to LOAD.
- WIN: game_won = 1, fade held at 15. If start = 1: level = 0, go to LOAD.
- Ignored inputs:
  - reach_final and restart are ignored outside PLAY.
  - start is ignored outside IDLE and WIN.
- level never exceeds NUM_LEVELS-1; no wrap-around occurs except through WIN then start.
- fade saturates at 0 and 15; it never wraps.
- Table indexing: entry i = TAB[10*i+9 : 10*i].

Test Plan:
1. Reset, then start pulse (FADE_DIV = 2) -> LOAD cycle shows spawn_load = 1, Teleport_X/Y = 40/400, Spawn_X/Y = 560/40. fade = 15 then steps to 0 over 30 cycles. PLAY is entered on cycle 31 after LOAD, with freeze = 0 and teleport_clear = 0.
2. In PLAY level 0, assert reach_final -> teleport_clear = 1 next cycle. fade climbs 0 to 15 over 30 cycles. level becomes 1, LOAD loads Teleport_X/Y = 300/40 and Spawn_X/Y = 300/400.
3. In PLAY level 2, assert restart -> full fade-out then LOAD. level stays 2 and Spawn_X/Y = 40/40 reloads.
4. In PLAY, restart and reach_final asserted in the same cycle -> level advances, i.e. reach_final priority.
5. Clear level 3 (NUM_LEVELS = 4) -> WIN with game_won = 1 and fade = 15. reach_final pulses are ignored. start -> level = 0, LOAD reloads table entry 0.
6. Reset_n pulsed low mid-FADE_OUT at level 1 -> outputs take reset values without waiting for a clock edge. reach_final asserted in IDLE does not leave IDLE.
